// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter that merges N valid/ready requesters onto one registered output stage.
// A multi-beat packet keeps its grant until the beat carrying last is accepted.
module vr_rr_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] req_data_i,
    input  logic [N-1:0]    req_last_i,
    input  logic [N-1:0]    req_valid_i,
    output logic [N-1:0]    req_ready_o,
    output logic [DW-1:0]   data_o,
    output logic            last_o,
    output logic [SW-1:0]   src_o,
    output logic            valid_o,
    input  logic            ready_i
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam int unsigned   LastIdxInt = N - 1;
    localparam logic [SW-1:0] LastIdx    = LastIdxInt[SW-1:0];
    localparam logic [SW:0]   NumReq     = N[SW:0];

    state_e          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   lk_q, lk_d;

    logic            valid_q;
    logic [DW-1:0]   data_q;
    logic            last_q;
    logic [SW-1:0]   src_q;

    logic            out_ready;
    logic            grant_valid;
    logic [SW-1:0]   grant_idx;
    logic [SW:0]     cand;
    logic            xfer;
    logic [DW-1:0]   sel_data;
    logic            sel_last;
    logic [SW-1:0]   next_ptr;

    assign out_ready = !valid_q || ready_i;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (state_q == StLocked) begin
            grant_valid = req_valid_i[lk_q];
            grant_idx   = lk_q;
        end else begin
            // Scan from the farthest offset back so the nearest valid requester at/after ptr wins.
            for (int i = N - 1; i >= 0; i--) begin
                cand = {1'b0, ptr_q} + i[SW:0];
                if (cand >= NumReq) begin
                    cand = cand - NumReq;
                end
                if (req_valid_i[cand[SW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[SW-1:0];
                end
            end
        end
    end

    assign xfer = grant_valid && out_ready;

    always_comb begin
        req_ready_o = '0;
        if (xfer) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == k[SW-1:0]) begin
                sel_data = req_data_i[k*DW +: DW];
            end
        end
    end

    assign sel_last = req_last_i[grant_idx];
    assign next_ptr = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lk_d    = lk_q;
        if (xfer) begin
            unique case (state_q)
                StIdle: begin
                    if (sel_last) begin
                        ptr_d = next_ptr;
                    end else begin
                        state_d = StLocked;
                        lk_d    = grant_idx;
                    end
                end
                StLocked: begin
                    // While locked grant_idx equals lk_q, so next_ptr is lk+1 mod N.
                    if (sel_last) begin
                        state_d = StIdle;
                        ptr_d   = next_ptr;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            lk_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lk_q    <= lk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
        end else if (out_ready) begin
            valid_q <= xfer;
            if (xfer) begin
                data_q <= sel_data;
                last_q <= sel_last;
                src_q  <= grant_idx;
            end
        end
    end

    assign data_o  = data_q;
    assign last_o  = last_q;
    assign src_o   = src_q;
    assign valid_o = valid_q;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready_o));

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Scoreboard bench for vr_rr_arbiter: a rule-level model predicts grants and pushes expected
// beats; a monitor pops them as the output stage hands beats downstream.
module tb_vr_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         s;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   req_data = '0;
    logic [3:0]    req_last = '0;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [7:0]    data_o;
    logic          last_o;
    logic [1:0]    src_o;
    logic          valid_o;
    logic          ready_i = 1'b0;

    // Second instance with non-power-of-two N for wrap-around.
    logic          rst3_n = 1'b0;
    logic [23:0]   data3 = 24'hC2B1A0;
    logic [2:0]    last3 = 3'b111;
    logic [2:0]    valid3 = 3'b111;
    logic [2:0]    ready3;
    logic [7:0]    data3_o;
    logic          last3_o;
    logic [1:0]    src3_o;
    logic          valid3_o;
    logic          n3_done = 1'b0;

    int            n_chk = 0;
    int            n_err = 0;
    beat_t         sb[$];

    // Reference model state (rule-level)
    int            m_ptr = 0;
    bit            m_locked = 1'b0;
    int            m_lk = 0;
    bit            m_valid = 1'b0;

    always #5 clk = ~clk;

    vr_rr_arbiter #(.DW(8), .N(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .data_o      (data_o),
        .last_o      (last_o),
        .src_o       (src_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    vr_rr_arbiter #(.DW(8), .N(3)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst3_n),
        .req_data_i  (data3),
        .req_last_i  (last3),
        .req_valid_i (valid3),
        .req_ready_o (ready3),
        .data_o      (data3_o),
        .last_o      (last3_o),
        .src_o       (src3_o),
        .valid_o     (valid3_o),
        .ready_i     (1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Predict this cycle's grant from the arbitration rules and record the expected beat.
    task automatic model_step();
        bit         o_rdy;
        bit         found;
        int         g;
        logic [3:0] exp_rdy;
        if (!rst_n) begin
            m_ptr = 0; m_locked = 1'b0; m_lk = 0; m_valid = 1'b0;
            sb.delete();
            return;
        end
        chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        o_rdy = !m_valid || ready_i;
        found = 1'b0;
        g = 0;
        if (m_locked) begin
            found = req_valid[m_lk];
            g = m_lk;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_valid[(m_ptr + i) % N]) begin
                    found = 1'b1;
                    g = (m_ptr + i) % N;
                end
            end
        end
        exp_rdy = '0;
        if (found && o_rdy) exp_rdy[g] = 1'b1;
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        if (found && o_rdy) begin
            sb.push_back('{d: req_data[g*DW +: DW], l: req_last[g], s: g});
            if (req_last[g]) begin
                m_locked = 1'b0;
                m_ptr = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_lk = g;
            end
        end
        if (o_rdy) m_valid = found;
    endtask

    task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                         input logic [31:0] d, input logic rst);
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        ready_i   = rdy;
        req_data  = d;
        rst_n     = !rst;
        #1;
        model_step();
    endtask

    // Monitor: a beat leaves the output stage when valid_o && ready_i at the coming edge.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL beat_expected at %0t: got src %0d with no beat predicted",
                             $time, src_o);
                end else begin
                    b = sb.pop_front();
                    chk("data_o", {24'd0, data_o}, {24'd0, b.d});
                    chk("last_o", {31'd0, last_o}, {31'd0, b.l});
                    chk("src_o", {30'd0, src_o}, b.s);
                end
            end
        end
    end

    // N=3: all single-beat requests must rotate 0,1,2,0,...
    initial begin
        logic [7:0] d3exp [3];
        d3exp = '{8'hA0, 8'hB1, 8'hC2};
        @(negedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("n3_ready", {29'd0, ready3}, 1 << (i % 3));
            if (i > 0) begin
                chk("n3_src", {30'd0, src3_o}, (i - 1) % 3);
                chk("n3_data", {24'd0, data3_o}, {24'd0, d3exp[(i - 1) % 3]});
                chk("n3_valid", {31'd0, valid3_o}, 1);
            end
        end
        n3_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d4;
        d4 = {8'h43, 8'h32, 8'h21, 8'h10};

        // Plain round-robin after reset
        cycle(4'hF, 4'hF, 1'b1, d4, 1'b1);
        for (int i = 0; i < 6; i++) cycle(4'hF, 4'hF, 1'b1, d4, 1'b0);

        // Packet from 2 (ptr is 2 here) while 0 and 3 wait; then 3, then 0
        cycle(4'b1101, 4'b1001, 1'b1, 32'h33_22_11_00, 1'b0);
        cycle(4'b1101, 4'b1001, 1'b1, 32'h33_23_11_00, 1'b0);
        cycle(4'b1101, 4'b1101, 1'b1, 32'h33_24_11_00, 1'b0);
        cycle(4'b1101, 4'b1101, 1'b1, 32'h33_25_11_00, 1'b0);
        cycle(4'b0001, 4'b1101, 1'b1, 32'h33_25_11_00, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, d4, 1'b0);

        // Stall with 0xA5 held in the output stage
        cycle(4'b0010, 4'b0010, 1'b1, 32'h00_00_A5_00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b1111, 4'hF, 1'b0, d4, 1'b0);
        cycle(4'b1111, 4'hF, 1'b1, d4, 1'b0);
        cycle(4'b0000, 4'h0, 1'b1, d4, 1'b0);
        cycle(4'b0000, 4'h0, 1'b1, d4, 1'b0);

        // Locked on 1, valid drops while 0 waits, then 1 finishes and 0 follows
        cycle(4'b0010, 4'b0000, 1'b1, 32'h00_00_51_00, 1'b0);
        cycle(4'b0001, 4'b0001, 1'b1, 32'h00_00_52_0F, 1'b0);
        cycle(4'b0001, 4'b0001, 1'b1, 32'h00_00_53_0F, 1'b0);
        cycle(4'b0011, 4'b0011, 1'b1, 32'h00_00_54_0F, 1'b0);
        cycle(4'b0001, 4'b0001, 1'b1, 32'h00_00_55_0E, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b1, d4, 1'b0);

        // Reset mid-packet while locked on 3
        cycle(4'b1000, 4'b0000, 1'b1, 32'h77_00_00_00, 1'b0);
        cycle(4'b1000, 4'b0000, 1'b0, 32'h78_00_00_00, 1'b0);
        cycle(4'hF, 4'hF, 1'b1, d4, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'hF, 4'hF, 1'b1, d4, 1'b0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(4'($urandom), 4'($urandom) | 4'($urandom), $urandom_range(0, 3) != 0,
                  $urandom, $urandom_range(0, 199) == 0);
        end

        // Drain
        for (int i = 0; i < 4; i++) cycle(4'h0, 4'h0, 1'b1, 32'h0, 1'b0);
        chk("sb_drained", sb.size(), 0);
        chk("n3_done", {31'd0, n3_done}, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vr_rr_arbiter.md
Name: vr_rr_arbiter

Overview:
- Shares one valid/ready output channel among N requesters using round-robin arbitration.
- Packet-aware: once a requester starts a multi-beat packet, its grant is locked until the beat carrying last is accepted.
- The output is a registered valid/ready stage (1-cycle latency, full throughput). It sits upstream of the 8-bit valid/ready register slices in the datapath.

Parameters:
- DW, 8, data width per beat.
- N, 4, number of requesters (2..8).
- SW, $clog2(N), source-index width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_data_i  in  N*DW  requester data; slice k = bits [k*DW +: DW].
- req_last_i  in  N  last beat of packet, per requester.
- req_valid_i  in  N  requester valid.
- req_ready_o  out  N  requester ready; at most one bit is high per cycle.
- data_o  out  DW  registered output data.
- last_o  out  1  registered last.
- src_o  out  SW  index of the requester that supplied the current output beat.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - data_o=0, last_o=0, src_o=0, valid_o=0.
  - Round-robin pointer ptr=0; state=IDLE; lock index lk=0.
- Output stage:
  - out_ready = !valid_o || ready_i.
  - Transfer on requester k when req_valid_i[k] && req_ready_o[k].
  - On a transfer at edge t: data_o, last_o and src_o take k's values, and valid_o=1, visible after t.
  - If out_ready and there is no transfer, valid_o goes to 0.
  - If !out_ready, all outputs hold.
  - Back-to-back transfers sustain one beat per cycle while ready_i=1.
- Grant (combinational):
  - IDLE: g = first index in the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with req_valid_i high.
  - LOCKED: g = lk if req_valid_i[lk], else no grant. Other requesters stay blocked even if valid.
  - req_ready_o = one-hot(g) gated by out_ready; all-zero if no grant.
  - req_ready_o must not depend combinationally on ready_i except through out_ready.
- State machine (updates only on a transfer from k):
  - IDLE, req_last_i[k]=1: stay IDLE; ptr = (k+1) mod N.
  - IDLE, req_last_i[k]=0: go to LOCKED; lk=k; ptr unchanged.
  - LOCKED, req_last_i[k]=1: go to IDLE; ptr = (lk+1) mod N.
  - LOCKED, req_last_i[k]=0: stay LOCKED.
  - No transfer: state, ptr and lk hold.
- Wrap-around: ptr = N-1 followed by a transfer from N-1 gives ptr=0. Index arithmetic is mod N and valid for non-power-of-2 N.
- Requesters whose valid drops before grant lose nothing; they are re-evaluated each cycle.
- Simultaneous events: the output slot being consumed (ready_i=1) and refilled in the same cycle is legal and gives a continuous valid_o.
- Reset mid-packet: state returns to IDLE and the partial packet is abandoned. Any beat held in data_o is dropped (valid_o=0).
- Single-beat-only traffic (all last=1) reduces to plain round-robin.

Test Plan:
- Reset with all four requesters valid, last=1, data 0x10/0x21/0x32/0x43, ready_i=1 -> src_o sequence 0,1,2,3,0; data_o 0x10,0x21,0x32,0x43,0x10; valid_o high every cycle from the cycle after the first transfer.
- Only requester 2 valid for 3 beats, last on beat 3, with requesters 0 and 3 also valid -> src_o 2,2,2, then 3, then 0; req_ready_o[0] and req_ready_o[3] stay 0 during the packet.
- Hold ready_i=0 for 4 cycles with valid_o=1, data_o=0xA5 -> data_o, src_o and valid_o are stable; all req_ready_o are 0; the next beat follows the first cycle ready_i=1.
- Locked requester 1 drops valid mid-packet while requester 0 is valid -> no grant, valid_o goes to 0 after the drain. Requester 1 resumes and completes; requester 0 is granted next.
- Assert rst_n=0 for one cycle while LOCKED on requester 3 with valid_o=1 -> valid_o=0, state IDLE, ptr=0. With all requesters valid, requester 0 is granted first.
- N=3 instance: requester 2 transfers with last=1 -> ptr wraps to 0; next grant goes to requester 0 when all are valid.
